// File: rtl/shift_unit_seq.sv
// Iterative shifter: moves the operand one bit per clock, start/done handshake.
// Define SHIFT_ARITH_EN to honour 'arith' (sign fill on right shifts).
module shift_unit_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   toshift,
    input  logic [SHAMT_W-1:0] number,
    input  logic               direction,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   shifted
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   shifted_q, shifted_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               dir_q, dir_d;
    logic               arith_q, arith_d;
    logic               fill;
    logic [WIDTH-1:0]   step;

`ifdef SHIFT_ARITH_EN
    assign fill = arith_q & work_q[WIDTH-1];
`else
    logic unused_arith;
    assign unused_arith = arith_q;
    assign fill         = 1'b0;
`endif

    assign step = dir_q ? {fill, work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        shifted_d = shifted_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        arith_d   = arith_q;
        unique case (state_q)
            // DONE accepts a new request exactly like IDLE so ops can run back to back.
            StIdle, StDone: begin
                state_d = StIdle;
                if (start) begin
                    work_d  = toshift;
                    cnt_d   = number;
                    dir_d   = direction;
                    arith_d = arith;
                    if (number == '0) begin
                        state_d   = StDone;
                        shifted_d = toshift;
                    end else begin
                        state_d = StShift;
                    end
                end
            end
            StShift: begin
                work_d = step;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_q <= SHAMT_W'(1)) begin
                    state_d   = StDone;
                    shifted_d = step;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            work_q    <= '0;
            shifted_q <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            arith_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            shifted_q <= shifted_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            arith_q   <= arith_d;
        end
    end

    assign busy    = (state_q == StShift);
    assign done    = (state_q == StDone);
    assign shifted = shifted_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Bench for shift_unit_seq: per-cycle comparison against an arithmetic model plus directed cases.
module tb_shift_unit_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] toshift = '0;
    logic [4:0]  number = '0;
    logic        direction = 1'b0;
    logic        arith = 1'b0;
    logic        busy, done;
    logic [31:0] shifted;

`ifdef SHIFT_ARITH_EN
    localparam bit ArithEn = 1'b1;
`else
    localparam bit ArithEn = 1'b0;
`endif

    int checks = 0;
    int failures = 0;

    shift_unit_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .toshift(toshift), .number(number),
        .direction(direction), .arith(arith), .busy(busy), .done(done), .shifted(shifted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int n, input bit d,
                                              input bit a);
        if (!d) return x << n;
        if (a && ArithEn) return 32'($signed(x) >>> n);
        return x >> n;
    endfunction

    // Model: an op accepted at edge e with amount n is busy after edges e..e+n-1 and done
    // after edge e+n; a new request is accepted only once the edge after the done cycle comes.
    int          cyc = 0;
    bit          mvalid = 0;
    bit          mactive = 0;
    int          done_edge = -1;
    logic [31:0] mres = '0;
    logic [31:0] mshift = '0;
    bit          exp_busy = 0;
    bit          exp_done = 0;

    always @(posedge clk) begin : model
        int e, de;
        bit act, v;
        logic [31:0] r, sh;
        e = cyc + 1; de = done_edge; act = mactive; r = mres; sh = mshift; v = mvalid;
        if (reset) begin
            v = 1; act = 0; sh = '0;
        end else if (v) begin
            if (start && (!act || e > de)) begin
                act = 1;
                de  = e + int'(number);
                r   = ref_shift(toshift, int'(number), direction, arith);
            end
            if (act && e == de) sh = r;
        end
        cyc       <= e;
        mvalid    <= v;
        mactive   <= act;
        done_edge <= de;
        mres      <= r;
        mshift    <= sh;
        exp_busy  <= act && (e < de);
        exp_done  <= act && (e == de);
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_busy", 64'(busy), 64'(exp_busy));
            chk("model_done", 64'(done), 64'(exp_done));
            chk("model_shifted", 64'(shifted), 64'(mshift));
        end
    end

    task automatic wait_done(output int lat, output int nb, output bit got);
        lat = 0; nb = 0; got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (done) got = 1;
            else if (busy) nb++;
        end
    endtask

    task automatic run_op(input string nm, input logic [31:0] x, input logic [4:0] n,
                          input logic d, input logic a, input logic [31:0] expv, input int explat);
        int lat, nb;
        bit got;
        @(posedge clk); #1;
        start = 1; toshift = x; number = n; direction = d; arith = a;
        @(posedge clk); #1;
        // Scramble inputs after acceptance; the registered operands must not notice.
        start = 0; toshift = ~x; number = ~n; direction = ~d; arith = ~a;
        wait_done(lat, nb, got);
        chk({nm, "_done_seen"}, 64'(got), 1);
        chk({nm, "_latency"}, 64'(lat), 64'(explat));
        chk({nm, "_busy_cycles"}, 64'(nb), 64'(n));
        chk({nm, "_shifted"}, 64'(shifted), 64'(expv));
    endtask

    initial begin : stim
        int lat, nb, cnt;
        bit got;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_done", 64'(done), 0);
        chk("reset_shifted", 64'(shifted), 0);

        run_op("t3_zero", 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 32'hDEADBEEF, 1);
        run_op("t2_left4", 32'h00000001, 5'd4, 1'b0, 1'b0, 32'h00000010, 5);
        run_op("t1_right31", 32'h80000000, 5'd31, 1'b1, 1'b0, 32'h00000001, 32);
        run_op("t6_arith31", 32'h80000000, 5'd31, 1'b1, 1'b1,
               ArithEn ? 32'hFFFFFFFF : 32'h00000001, 32);
        run_op("arith_left", 32'h80000003, 5'd1, 1'b0, 1'b1, 32'h00000006, 2);
        run_op("right_mixed", 32'hF0F0F0F0, 5'd7, 1'b1, 1'b0, 32'h01E1E1E1, 8);

        // Second start arrives mid-operation and must be ignored.
        @(posedge clk); #1;
        start = 1; toshift = 32'h000000F0; number = 5'd4; direction = 1; arith = 0;
        @(posedge clk); #1 start = 0;
        @(posedge clk); #1;
        start = 1; toshift = 32'hFFFFFFFF; number = 5'd8; direction = 0;
        @(posedge clk); #1 start = 0;
        wait_done(lat, nb, got);
        chk("t4_done_seen", 64'(got), 1);
        chk("t4_shifted", 64'(shifted), 32'h0000000F);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("t4_no_extra_done", 64'(cnt), 0);

        // Start held through DONE: the second op starts immediately after the first.
        @(posedge clk); #1;
        start = 1; toshift = 32'h00000001; number = 5'd3; direction = 0; arith = 0;
        @(posedge clk); #1;
        toshift = 32'h00000080; number = 5'd2; direction = 1;
        wait_done(lat, nb, got);
        chk("b2b_first_latency", 64'(lat), 4);
        chk("b2b_first_shifted", 64'(shifted), 32'h00000008);
        @(posedge clk); #1 start = 0;
        wait_done(lat, nb, got);
        chk("b2b_second_seen", 64'(got), 1);
        chk("b2b_gap", 64'(lat), 3);
        chk("b2b_second_shifted", 64'(shifted), 32'h00000020);

        // Reset three cycles into a 20-bit shift aborts it.
        @(posedge clk); #1;
        start = 1; toshift = 32'h12345678; number = 5'd20; direction = 0;
        @(posedge clk); #1 start = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("t5_busy", 64'(busy), 0);
        chk("t5_done", 64'(done), 0);
        chk("t5_shifted", 64'(shifted), 0);
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("t5_no_done", 64'(cnt), 0);

        run_op("after_reset", 32'h0000ABCD, 5'd16, 1'b0, 1'b0, 32'hABCD0000, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
